// File: rtl/frame_capture_packer.sv
// Captures one video frame of 1-bit pixels after an arm pulse and packs them
// MSB-first into bytes written sequentially to an SRAM with an active-low strobe.
module frame_capture_packer #(
  parameter int ADDR_W   = 18,
  parameter int MAX_ADDR = 262143
) (
  input  logic              FPGA_clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              pix_en,
  input  logic              rpi_DEN,
  input  logic              rpi_v_sync,
  input  logic              rpi_color,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        wdata,
  output logic              we,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  typedef enum logic [2:0] {IDLE, WAIT_VS, CAPTURE, FLUSH, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ADDR);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]        wdata_nxt;
  logic              we_nxt;
  logic              overflow_nxt;
  logic              ovf_pend, ovf_pend_nxt;
  logic [7:0]        shreg, shreg_nxt, shreg_pix, shreg_eff;
  logic [2:0]        cnt, cnt_nxt, cnt_pix, cnt_eff;
  logic              vs_prev;
  logic              vs_rise, pix, at_max, completes;

  function automatic logic [7:0] left_align(input logic [7:0] bits, input logic [2:0] n);
    return bits << (4'd8 - {1'b0, n});
  endfunction

  assign vs_rise   = rpi_v_sync & ~vs_prev;
  assign pix       = pix_en & rpi_DEN;
  assign at_max    = (addr == LAST_ADDR);
  assign shreg_pix = {shreg[6:0], rpi_color};
  assign cnt_pix   = cnt + 3'd1;
  assign shreg_eff = pix ? shreg_pix : shreg;
  assign cnt_eff   = pix ? cnt_pix : cnt;
  assign completes = pix && (cnt == 3'd7);

  assign busy = (state == WAIT_VS) || (state == CAPTURE);
  assign done = (state == DONE);

  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr;
    wdata_nxt    = wdata;
    we_nxt       = 1'b1;
    overflow_nxt = overflow;
    ovf_pend_nxt = 1'b0;
    shreg_nxt    = shreg;
    cnt_nxt      = cnt;

    // Closing a write cycle: advance the address, or pin it and flag overflow.
    if (!we) begin
      if (ovf_pend)
        overflow_nxt = 1'b1;
      else if (!at_max)
        addr_nxt = addr + ADDR_W'(1);
    end

    case (state)
      IDLE, DONE: begin
        if (arm) begin
          state_nxt    = WAIT_VS;
          addr_nxt     = '0;
          cnt_nxt      = '0;
          shreg_nxt    = '0;
          overflow_nxt = 1'b0;
        end
      end
      WAIT_VS: begin
        if (vs_rise)
          state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (completes) begin
          we_nxt    = 1'b0;
          wdata_nxt = shreg_pix;
          shreg_nxt = shreg_pix;
          cnt_nxt   = '0;
          if (at_max) begin
            ovf_pend_nxt = 1'b1;
            state_nxt    = FLUSH;
          end else if (vs_rise) begin
            state_nxt = FLUSH;
          end
        end else begin
          shreg_nxt = shreg_eff;
          cnt_nxt   = cnt_eff;
          if (vs_rise) begin
            state_nxt = FLUSH;
            cnt_nxt   = '0;
            if (cnt_eff != 3'd0) begin
              we_nxt    = 1'b0;
              wdata_nxt = left_align(shreg_eff, cnt_eff);
            end
          end
        end
      end
      // FLUSH is exactly one cycle: the final write cycle when there is one.
      FLUSH: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge FPGA_clk) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      wdata    <= '0;
      we       <= 1'b1;
      overflow <= 1'b0;
      ovf_pend <= 1'b0;
      shreg    <= '0;
      cnt      <= '0;
      vs_prev  <= 1'b0;
    end else begin
      state    <= state_nxt;
      addr     <= addr_nxt;
      wdata    <= wdata_nxt;
      we       <= we_nxt;
      overflow <= overflow_nxt;
      ovf_pend <= ovf_pend_nxt;
      shreg    <= shreg_nxt;
      cnt      <= cnt_nxt;
      vs_prev  <= rpi_v_sync;
    end
  end

endmodule

// File: tb/tb_frame_capture_packer.sv
// Directed bench for frame_capture_packer: a default-size instance plus a
// MAX_ADDR=3 instance driven by the same inputs; writes are logged per instance.
module tb_frame_capture_packer;

  logic        clk = 1'b0;
  logic        rst, arm, pix_en, rpi_DEN, rpi_v_sync, rpi_color;
  logic [17:0] addr_a;
  logic [7:0]  wdata_a;
  logic        we_a, busy_a, done_a, ovf_a;
  logic [1:0]  addr_b;
  logic [7:0]  wdata_b;
  logic        we_b, busy_b, done_b, ovf_b;

  int checks = 0;
  int errors = 0;

  logic [17:0] log_addr_a [0:255];
  logic [7:0]  log_data_a [0:255];
  int          nw_a = 0;
  logic [1:0]  log_addr_b [0:255];
  logic [7:0]  log_data_b [0:255];
  int          nw_b = 0;

  frame_capture_packer #(.ADDR_W(18), .MAX_ADDR(262143)) dut_a (
    .FPGA_clk(clk), .rst(rst), .arm(arm), .pix_en(pix_en), .rpi_DEN(rpi_DEN),
    .rpi_v_sync(rpi_v_sync), .rpi_color(rpi_color), .addr(addr_a), .wdata(wdata_a),
    .we(we_a), .busy(busy_a), .done(done_a), .overflow(ovf_a));

  frame_capture_packer #(.ADDR_W(2), .MAX_ADDR(3)) dut_b (
    .FPGA_clk(clk), .rst(rst), .arm(arm), .pix_en(pix_en), .rpi_DEN(rpi_DEN),
    .rpi_v_sync(rpi_v_sync), .rpi_color(rpi_color), .addr(addr_b), .wdata(wdata_b),
    .we(we_b), .busy(busy_b), .done(done_b), .overflow(ovf_b));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we_a === 1'b0 && nw_a < 256) begin
      log_addr_a[nw_a] = addr_a;
      log_data_a[nw_a] = wdata_a;
      nw_a = nw_a + 1;
    end
    if (we_b === 1'b0 && nw_b < 256) begin
      log_addr_b[nw_b] = addr_b;
      log_data_b[nw_b] = wdata_b;
      nw_b = nw_b + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask

  task automatic vsync();
    rpi_v_sync = 1'b1;
    tick(1);
    rpi_v_sync = 1'b0;
    tick(1);
  endtask

  task automatic pix(input logic c, input logic den);
    pix_en    = 1'b1;
    rpi_DEN   = den;
    rpi_color = c;
    tick(1);
    pix_en  = 1'b0;
    rpi_DEN = 1'b0;
    tick(3);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) pix(b[i], 1'b1);
  endtask

  int base_a, base_b;
  logic [7:0] pat;

  initial begin
    rst = 1'b1; arm = 1'b0; pix_en = 1'b0; rpi_DEN = 1'b0;
    rpi_v_sync = 1'b0; rpi_color = 1'b0;
    tick(3);
    chk("rst_addr", addr_a, 0);
    chk("rst_wdata", wdata_a, 0);
    chk("rst_we", we_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_ovf", ovf_a, 0);
    rst = 1'b0;
    tick(2);

    // Frame AA, F0 with exact write timing and an ignored mid-frame arm
    base_a = nw_a;
    pulse_arm();
    chk("t1_busy", busy_a, 1);
    vsync();
    pat = 8'hAA;
    for (int i = 7; i >= 1; i--) pix(pat[i], 1'b1);
    pix_en = 1'b1; rpi_DEN = 1'b1; rpi_color = 1'b0;
    tick(1);
    pix_en = 1'b0; rpi_DEN = 1'b0;
    chk("t1_we_low", we_a, 0);
    chk("t1_wdata", wdata_a, 8'hAA);
    chk("t1_addr_during", addr_a, 0);
    tick(1);
    chk("t1_we_high", we_a, 1);
    chk("t1_addr_after", addr_a, 1);
    tick(2);
    pix(1, 1); pix(1, 1); pix(1, 1); pix(1, 1);
    pulse_arm();
    pix(0, 1); pix(0, 1); pix(0, 1); pix(0, 1);
    vsync();
    tick(3);
    chk("t1_nwrites", nw_a - base_a, 2);
    chk("t1_w0_addr", log_addr_a[base_a], 0);
    chk("t1_w0_data", log_data_a[base_a], 8'hAA);
    chk("t1_w1_addr", log_addr_a[base_a+1], 1);
    chk("t1_w1_data", log_data_a[base_a+1], 8'hF0);
    chk("t1_done", done_a, 1);
    chk("t1_busy_end", busy_a, 0);
    chk("t1_addr_end", addr_a, 2);

    // 11 white pixels: one full byte plus a left-aligned partial flush
    base_a = nw_a;
    pulse_arm();
    chk("t2_done_clr", done_a, 0);
    chk("t2_addr_clr", addr_a, 0);
    vsync();
    for (int i = 0; i < 11; i++) pix(1, 1);
    vsync();
    tick(3);
    chk("t2_nwrites", nw_a - base_a, 2);
    chk("t2_w0", {log_addr_a[base_a], log_data_a[base_a]}, {18'd0, 8'hFF});
    chk("t2_w1", {log_addr_a[base_a+1], log_data_a[base_a+1]}, {18'd1, 8'hE0});
    chk("t2_done", done_a, 1);
    chk("t2_addr", addr_a, 2);

    // Pre-vsync pixels and DEN=0 strobes ignored
    base_a = nw_a;
    pulse_arm();
    for (int i = 0; i < 4; i++) pix(1, 1);
    vsync();
    pat = 8'hCC;
    for (int i = 7; i >= 0; i--) begin
      pix(pat[i], 1'b1);
      pix(~pat[i], 1'b0);
    end
    vsync();
    tick(3);
    chk("t3_nwrites", nw_a - base_a, 1);
    chk("t3_w0", {log_addr_a[base_a], log_data_a[base_a]}, {18'd0, 8'hCC});
    chk("t3_addr", addr_a, 1);
    chk("t3_done", done_a, 1);

    // 8th pixel coincident with vsync: one write, no flush
    base_a = nw_a;
    pulse_arm();
    vsync();
    for (int i = 0; i < 7; i++) pix(1, 1);
    rpi_v_sync = 1'b1; pix_en = 1'b1; rpi_DEN = 1'b1; rpi_color = 1'b0;
    tick(1);
    rpi_v_sync = 1'b0; pix_en = 1'b0; rpi_DEN = 1'b0;
    tick(5);
    chk("t6_nwrites", nw_a - base_a, 1);
    chk("t6_w0", {log_addr_a[base_a], log_data_a[base_a]}, {18'd0, 8'hFE});
    chk("t6_done", done_a, 1);
    chk("t6_addr", addr_a, 1);

    // Overflow on the MAX_ADDR=3 instance: 40 pixels, bytes 00,FF,00,FF then stop
    base_b = nw_b;
    pulse_arm();
    vsync();
    for (int i = 0; i < 40; i++) pix(((i >> 3) & 1) != 0, 1'b1);
    tick(2);
    chk("t4_nwrites", nw_b - base_b, 4);
    for (int k = 0; k < 4; k++) begin
      chk("t4_w_addr", log_addr_b[base_b+k], k);
      chk("t4_w_data", log_data_b[base_b+k], (k % 2 == 1) ? 8'hFF : 8'h00);
    end
    chk("t4_ovf", ovf_b, 1);
    chk("t4_addr", addr_b, 3);
    chk("t4_done", done_b, 1);
    vsync();
    tick(3);
    chk("t4_nwrites_final", nw_b - base_b, 4);

    // Reset in the write cycle, then a clean restart
    pulse_arm();
    chk("t5_ovf_clr", ovf_b, 0);
    vsync();
    for (int i = 0; i < 7; i++) pix(1, 1);
    pix_en = 1'b1; rpi_DEN = 1'b1; rpi_color = 1'b1;
    tick(1);
    pix_en = 1'b0; rpi_DEN = 1'b0;
    chk("t5_we_low", we_a, 0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t5_we", we_a, 1);
    chk("t5_addr", addr_a, 0);
    chk("t5_wdata", wdata_a, 0);
    chk("t5_busy", busy_a, 0);
    chk("t5_done", done_a, 0);
    tick(2);
    chk("t5_idle_hold", busy_a, 0);
    base_a = nw_a;
    pulse_arm();
    vsync();
    send_byte(8'h5A);
    vsync();
    tick(3);
    chk("t5_nwrites", nw_a - base_a, 1);
    chk("t5_w0", {log_addr_a[base_a], log_data_a[base_a]}, {18'd0, 8'h5A});
    chk("t5_done_end", done_a, 1);
    chk("t5_addr_end", addr_a, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
